conv_sequencer: RTL and testbench

//  Control FSM for the conv2d datapath. Counts image pixels into the image buffer, then walks

---
 rtl/conv_pkg.sv | 34 +++
 rtl/conv_sequencer_if.sv | 32 +++
 rtl/conv_tap_addr_gen.sv | 37 +++
 rtl/conv_sequencer.sv | 176 +++++++++++++++++
 tb/tb_conv_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// conv_sequencer shared types: FSM state encoding, default geometry,
// derived sizes and a width helper.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } conv_state_e;

  localparam int CONV_IMG_W  = 8;
  localparam int CONV_IMG_H  = 8;
  localparam int CONV_KSIZE  = 3;
  localparam int CONV_N_FILT = 2;
  localparam int CONV_PAD    = 0;

  localparam int CONV_OUT_W =
    CONV_IMG_W - CONV_KSIZE + 1 + 2 * CONV_PAD;
  localparam int CONV_OUT_H =
    CONV_IMG_H - CONV_KSIZE + 1 + 2 * CONV_PAD;
  localparam int CONV_N_TAPS = CONV_KSIZE * CONV_KSIZE;
  localparam int CONV_N_POS  = CONV_OUT_W * CONV_OUT_H;

  localparam int CONV_ADDR_W = 6;
  localparam int CONV_WIDX_W = 5;
  localparam int CONV_POS_W  = 6;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// conv_sequencer datapath bus: buffer strobes, tap controls and
// the result valid/ready handshake.
interface conv_sequencer_if;
  import conv_pkg::*;

  logic                   wr_en;
  logic [CONV_ADDR_W-1:0] wr_addr;
  logic [CONV_ADDR_W-1:0] rd_addr;
  logic                   pad;
  logic [CONV_WIDX_W-1:0] w_idx;
  logic                   acc_first;
  logic                   acc_en;
  logic                   filt_sel;
  logic                   out_valid;
  logic                   out_ready;
  logic [CONV_POS_W-1:0]  pos_idx;

  modport master (
    output wr_en, wr_addr, rd_addr, pad,
    output w_idx, acc_first, acc_en,
    output filt_sel, out_valid, pos_idx,
    input  out_ready
  );

  modport slave (
    input  wr_en, wr_addr, rd_addr, pad,
    input  w_idx, acc_first, acc_en,
    input  filt_sel, out_valid, pos_idx,
    output out_ready
  );

endinterface

// File: rtl/conv_tap_addr_gen.sv
// Kernel tap -> image buffer address with zero-pad detection.
// Coordinates carry a guard bit so border taps go negative.
module conv_tap_addr_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PAD   = 0,
  parameter int CW    = 6,
  parameter int AW    = 6
) (
  input  logic [CW-1:0] i_ox,
  input  logic [CW-1:0] i_oy,
  input  logic [CW-1:0] i_kx,
  input  logic [CW-1:0] i_ky,
  output logic [AW-1:0] o_rd_addr,
  output logic          o_pad
);

  localparam int MW = AW + CW;
  localparam logic [CW-1:0] P = CW'(PAD);
  localparam logic [CW-1:0] W = CW'(IMG_W);
  localparam logic [CW-1:0] H = CW'(IMG_H);

  logic signed [CW-1:0] w_x;
  logic signed [CW-1:0] w_y;
  logic [MW-1:0]        w_lin;

  assign w_x = $signed(i_ox + i_kx - P);
  assign w_y = $signed(i_oy + i_ky - P);

  assign o_pad = w_x[CW-1] | w_y[CW-1]
               | (w_x >= $signed(W))
               | (w_y >= $signed(H));

  assign w_lin = MW'(w_y) * MW'(IMG_W) + MW'(w_x);
  assign o_rd_addr = o_pad ? '0 : AW'(w_lin);

endmodule

// File: rtl/conv_sequencer.sv
// conv2d control FSM: pixel load, then one kernel tap per cycle.
// CONV_SEQ_PERF_EN adds the perf_cycles frame counter.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_W  = CONV_IMG_W,
  parameter int IMG_H  = CONV_IMG_H,
  parameter int KSIZE  = CONV_KSIZE,
  parameter int N_FILT = CONV_N_FILT,
  parameter int PAD    = CONV_PAD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic start,
  input  logic pix_valid,
  conv_sequencer_if.master bus,
`ifdef CONV_SEQ_PERF_EN
  output logic [15:0] perf_cycles,
`endif
  output logic busy,
  output logic done
);

  localparam int OUT_W  = IMG_W - KSIZE + 1 + 2 * PAD;
  localparam int OUT_H  = IMG_H - KSIZE + 1 + 2 * PAD;
  localparam int N_TAPS = KSIZE * KSIZE;
  localparam int N_POS  = OUT_W * OUT_H;
  localparam int N_PIX  = IMG_W * IMG_H;
  localparam int KW = cw(KSIZE);
  localparam int FW = cw(N_FILT);
  localparam int XW = cw(OUT_W);
  localparam int YW = cw(OUT_H);
  localparam int CW = cw(IMG_W + IMG_H + KSIZE + 2 * PAD) + 1;

  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_LOAD = LOAD;
  localparam logic [2:0] S_RUN  = RUN;
  localparam logic [2:0] S_EMIT = EMIT;
  localparam logic [2:0] S_DONE = DONE;

  logic [2:0]             r_state;
  logic [CONV_ADDR_W-1:0] r_wr_addr;
  logic [KW-1:0]          r_kx;
  logic [KW-1:0]          r_ky;
  logic [FW-1:0]          r_filt;
  logic [XW-1:0]          r_ox;
  logic [YW-1:0]          r_oy;
  logic [CONV_POS_W-1:0]  r_pos;

  logic w_idle, w_load, w_run, w_emit, w_done;
  logic w_last_kx, w_last_ky, w_last_f;
  logic w_last_ox, w_last_pos, w_last_pix;
  logic w_pad;
  logic [CONV_ADDR_W-1:0] w_rd_addr;

  assign w_idle = (r_state == S_IDLE);
  assign w_load = (r_state == S_LOAD);
  assign w_run  = (r_state == S_RUN);
  assign w_emit = (r_state == S_EMIT);
  assign w_done = (r_state == S_DONE);

  assign w_last_kx  = (r_kx == KW'(KSIZE - 1));
  assign w_last_ky  = (r_ky == KW'(KSIZE - 1));
  assign w_last_f   = (r_filt == FW'(N_FILT - 1));
  assign w_last_ox  = (r_ox == XW'(OUT_W - 1));
  assign w_last_pos = (r_pos == CONV_POS_W'(N_POS - 1));
  assign w_last_pix = (r_wr_addr == CONV_ADDR_W'(N_PIX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wr_addr <= '0;
      r_kx      <= '0;
      r_ky      <= '0;
      r_filt    <= '0;
      r_ox      <= '0;
      r_oy      <= '0;
      r_pos     <= '0;
    end else if (ena) begin
      unique case (1'b1)
        w_idle: if (start) begin
          r_state   <= S_LOAD;
          r_wr_addr <= '0;
        end
        w_load: if (pix_valid) begin
          if (w_last_pix) begin
            r_wr_addr <= '0;
            r_state   <= S_RUN;
          end else begin
            r_wr_addr <= r_wr_addr + 1'b1;
          end
        end
        // kx fastest, then ky, then filter
        w_run: begin
          r_kx <= w_last_kx ? '0 : r_kx + 1'b1;
          if (w_last_kx) begin
            r_ky <= w_last_ky ? '0 : r_ky + 1'b1;
            if (w_last_ky) begin
              r_filt <= w_last_f ? '0 : r_filt + 1'b1;
              if (w_last_f) r_state <= S_EMIT;
            end
          end
        end
        w_emit: if (bus.out_ready) begin
          if (w_last_pos) begin
            r_pos   <= '0;
            r_ox    <= '0;
            r_oy    <= '0;
            r_state <= S_DONE;
          end else begin
            r_pos   <= r_pos + 1'b1;
            r_state <= S_RUN;
            if (w_last_ox) begin
              r_ox <= '0;
              r_oy <= r_oy + 1'b1;
            end else begin
              r_ox <= r_ox + 1'b1;
            end
          end
        end
        w_done: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  conv_tap_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .PAD   (PAD),
    .CW    (CW),
    .AW    (CONV_ADDR_W)
  ) u_addr (
    .i_ox      (CW'(r_ox)),
    .i_oy      (CW'(r_oy)),
    .i_kx      (CW'(r_kx)),
    .i_ky      (CW'(r_ky)),
    .o_rd_addr (w_rd_addr),
    .o_pad     (w_pad)
  );

  assign bus.wr_en     = pix_valid & w_load & ena;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.rd_addr   = (w_run & ~w_pad) ? w_rd_addr : '0;
  assign bus.pad       = w_run & w_pad;
  assign bus.w_idx     = CONV_WIDX_W'(r_filt * N_TAPS
                       + r_ky * KSIZE + r_kx);
  assign bus.acc_first = w_run & (r_kx == '0) & (r_ky == '0);
  assign bus.acc_en    = w_run & ena;
  assign bus.filt_sel  = r_filt[0];
  assign bus.out_valid = w_emit;
  assign bus.pos_idx   = r_pos;
  assign busy          = ~w_idle;
  assign done          = w_done;

`ifdef CONV_SEQ_PERF_EN
  logic [15:0] r_perf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf <= '0;
    end else if (ena) begin
      if (w_idle & start) begin
        r_perf <= '0;
      end else if ((w_load | w_run | w_emit) &&
                   r_perf != 16'hFFFF) begin
        r_perf <= r_perf + 16'd1;
      end
    end
  end

  assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: PAD=0 and PAD=1 instances driven in
// lockstep against a frame-level reference model.
module tb_conv_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic start = 1'b0;
  logic pix_valid = 1'b0;
  logic busy0, done0, busy1, done1;
`ifdef CONV_SEQ_PERF_EN
  logic [15:0] perf0, perf1;
`endif

  conv_sequencer_if if0();
  conv_sequencer_if if1();

  conv_sequencer u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .pix_valid (pix_valid),
    .bus       (if0),
`ifdef CONV_SEQ_PERF_EN
    .perf_cycles (perf0),
`endif
    .busy      (busy0),
    .done      (done0)
  );

  conv_sequencer #(.PAD(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .pix_valid (pix_valid),
    .bus       (if1),
`ifdef CONV_SEQ_PERF_EN
    .perf_cycles (perf1),
`endif
    .busy      (busy1),
    .done      (done1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [5:0] rd_addr;
    logic       pad;
    logic [4:0] w_idx;
    logic       acc_first;
    logic       acc_en;
    logic       filt_sel;
    logic       out_valid;
    logic [5:0] pos_idx;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t a0, a1;
  assign a0 = {if0.wr_en, if0.wr_addr, if0.rd_addr, if0.pad,
               if0.w_idx, if0.acc_first, if0.acc_en,
               if0.filt_sel, if0.out_valid, if0.pos_idx,
               busy0, done0};
  assign a1 = {if1.wr_en, if1.wr_addr, if1.rd_addr, if1.pad,
               if1.w_idx, if1.acc_first, if1.acc_en,
               if1.filt_sel, if1.out_valid, if1.pos_idx,
               busy1, done1};

  localparam int MI = 0, ML = 1, MR = 2, ME = 3, MD = 4;
  int m_mode[2], m_n[2], m_t[2], m_p[2], m_perf[2];
  int ow[2]   = '{6, 8};
  int padv[2] = '{0, 1};

  int n_err = 0;
  int n_chk = 0;
  int bcnt  = 0;
  int xcnt  = 0;

  typedef struct {
    logic       e;
    logic       s;
    logic       en;
    logic       first;
    logic [4:0] widx;
    logic [5:0] rd0;
    logic [5:0] rd1;
    logic       pad1;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic obs_t exp_out(int k, logic e, logic pv);
    obs_t o;
    int tap, kx, ky, x, y;
    o = '0;
    o.pos_idx = 6'(m_p[k]);
    o.wr_addr = 6'(m_n[k]);
    o.busy = (m_mode[k] != MI);
    o.done = (m_mode[k] == MD);
    if (m_mode[k] == ML) o.wr_en = e & pv;
    if (m_mode[k] == ME) o.out_valid = 1'b1;
    if (m_mode[k] == MR) begin
      tap = m_t[k] % 9;
      kx = tap % 3;
      ky = tap / 3;
      x = m_p[k] % ow[k] + kx - padv[k];
      y = m_p[k] / ow[k] + ky - padv[k];
      o.w_idx = 5'(m_t[k]);
      o.acc_first = (tap == 0);
      o.acc_en = e;
      o.filt_sel = (m_t[k] >= 9);
      if (x < 0 || x > 7 || y < 0 || y > 7) o.pad = 1'b1;
      else o.rd_addr = 6'(y * 8 + x);
    end
    return o;
  endfunction

  task automatic step(int k, logic e, logic s, logic pv,
                      logic r);
    if (!e) return;
    if (m_mode[k] inside {ML, MR, ME} && m_perf[k] < 65535)
      m_perf[k]++;
    case (m_mode[k])
      MI: if (s) begin
        m_mode[k] = ML; m_n[k] = 0; m_perf[k] = 0;
      end
      ML: if (pv) begin
        m_n[k]++;
        if (m_n[k] == 64) begin
          m_n[k] = 0; m_t[k] = 0; m_mode[k] = MR;
        end
      end
      MR: begin
        m_t[k]++;
        if (m_t[k] == 18) begin
          m_t[k] = 0; m_mode[k] = ME;
        end
      end
      ME: if (r) begin
        if (m_p[k] == ow[k] * ow[k] - 1) begin
          m_p[k] = 0; m_mode[k] = MD;
        end else begin
          m_p[k]++; m_mode[k] = MR;
        end
      end
      default: m_mode[k] = MI;
    endcase
  endtask

  task automatic tick(logic e, logic s, logic pv, logic r);
    @(negedge clk);
    ena = e; start = s; pix_valid = pv;
    if0.out_ready = r; if1.out_ready = r;
    #1;
    chk("out0", 32'(a0), 32'(exp_out(0, e, pv)));
    chk("out1", 32'(a1), 32'(exp_out(1, e, pv)));
    if (e && busy0 && !done0) bcnt++;
    if (e && if0.out_valid && r) xcnt++;
    step(0, e, s, pv, r);
    step(1, e, s, pv, r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst0", 32'(a0), 32'd0);
    chk("rst1", 32'(a1), 32'd0);
`ifdef CONV_SEQ_PERF_EN
    chk("rst_perf", 32'(perf0), 32'd0);
`endif
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = MI; m_n[k] = 0; m_t[k] = 0;
      m_p[k] = 0; m_perf[k] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_frame(int kind, int stall_pos);
    int g = 0;
    int st = 0;
    logic e, s, pv, r;
    while (!(m_mode[0] == MI && m_mode[1] == MI) && g < 20000) begin
      g++;
      e = 1'b1; s = 1'b0; pv = 1'b1; r = 1'b1;
      if (kind >= 2) e = ($urandom % 10) < 7;
      if (kind == 3) begin
        pv = 1'($urandom % 2);
        r  = 1'($urandom % 2);
      end
      if (kind >= 2 && m_mode[0] != MI && m_mode[1] != MI)
        s = ($urandom % 4) == 0;
      if (kind == 1 && m_mode[0] == ME && m_p[0] == stall_pos
          && st < 5) begin
        r = 1'b0; st++;
      end
      tick(e, s, pv, r);
    end
    chk("frame_timeout", 32'(g < 20000), 32'd1);
  endtask

  initial begin
    int rd0[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    int rd1[9] = '{0, 0, 0, 0, 0, 1, 0, 8, 9};
    int pd1[9] = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
    vec_t v;
    int g;

    for (int j = 0; j < 18; j++) begin
      v.e = 1'b1; v.s = (j == 7); v.en = 1'b1;
      v.first = (j % 9 == 0);
      v.widx = 5'(j);
      v.rd0 = 6'(rd0[j % 9]);
      v.rd1 = 6'(rd1[j % 9]);
      v.pad1 = 1'(pd1[j % 9]);
      if (j == 5) begin
        v.e = 1'b0; v.en = 1'b0;
        tv.push_back(v);
        v.e = 1'b1; v.en = 1'b1;
      end
      tv.push_back(v);
    end

    do_reset();

    // load + first position table, then clean frame
    bcnt = 0; xcnt = 0;
    tick(1, 1, 0, 1);
    for (int i = 0; i < 64; i++) tick(1, 0, 1, 1);
    foreach (tv[i]) begin
      tick(tv[i].e, tv[i].s, 1, 1);
      chk("tap", 32'({if0.acc_en, if0.acc_first, if0.w_idx,
                      if0.rd_addr, if1.rd_addr, if1.pad}),
                 32'({tv[i].en, tv[i].first, tv[i].widx,
                      tv[i].rd0, tv[i].rd1, tv[i].pad1}));
    end
    run_frame(0, 0);
    chk("frame_time", 32'(bcnt), 32'd748);
    chk("transfers", 32'(xcnt), 32'd36);
`ifdef CONV_SEQ_PERF_EN
    chk("perf0", 32'(perf0), 32'd748);
    chk("perf1", 32'(perf1), 32'd1280);
`endif

    // 5-cycle backpressure at position 7
    bcnt = 0; xcnt = 0;
    tick(1, 1, 0, 1);
    run_frame(1, 7);
    chk("stall_time", 32'(bcnt), 32'd753);
    chk("stall_xfers", 32'(xcnt), 32'd36);

    // reset while running position 20
    tick(1, 1, 0, 1);
    g = 0;
    while (!(m_mode[0] == MR && m_p[0] == 20) && g < 5000) begin
      g++;
      tick(1, 0, 1, 1);
    end
    chk("reach_pos20", 32'(g < 5000), 32'd1);
    tick(1, 0, 1, 1);
    tick(1, 0, 1, 1);
    do_reset();
    bcnt = 0;
    tick(1, 1, 0, 1);
    run_frame(0, 0);
    chk("after_rst", 32'(bcnt), 32'd748);

    // random clock-enable, ignored starts
    bcnt = 0;
    tick(1, 1, 0, 1);
    run_frame(2, 0);
    chk("ena_time", 32'(bcnt), 32'd748);
`ifdef CONV_SEQ_PERF_EN
    chk("perf_ena", 32'(perf0), 32'd748);
`endif

    repeat (2) begin
      tick(1, 1, 0, 1);
      run_frame(3, 0);
`ifdef CONV_SEQ_PERF_EN
      chk("perf_rnd0", 32'(perf0), 32'(m_perf[0]));
      chk("perf_rnd1", 32'(perf1), 32'(m_perf[1]));
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
